vertex_fetch_addr_gen: RTL and testbench

//  Parametrised successor to the single-counter vertex buffer address generator.

---
 rtl/vfetch_pkg.sv | 26 ++
 rtl/strip_vertex_sequencer.sv | 81 ++++++++
 rtl/vertex_fetch_addr_gen.sv | 195 +++++++++++++++++++
 tb/tb_vertex_fetch_addr_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfetch_pkg.sv
// Shared definitions for the vertex fetch address generator: mode codes,
// FSM state encoding and the strip corner remap helper.
package vfetch_pkg;

    localparam logic [1:0] MODE_LINEAR = 2'd0;
    localparam logic [1:0] MODE_STRIP  = 2'd1;
    localparam logic [1:0] MODE_REPEAT = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Offset (in vertices) from triangle k's first vertex to the vertex fetched
    // for corner c. Odd triangles swap their first two corners so that every
    // emitted triangle keeps the same winding.
    function automatic logic [1:0] strip_corner_offset(input logic odd_tri, input logic [1:0] corner);
        if (odd_tri && (corner != 2'd2)) begin
            return corner ^ 2'd1;
        end
        return corner;
    endfunction

endpackage

// File: rtl/strip_vertex_sequencer.sv
// Vertex ordering for the fetch walk. In STRIP mode tracks triangle k and
// corner c; in LINEAR/REPEAT it is a plain vertex counter (k only).
// All outputs describe the position being moved to on this cycle's load/step,
// so the parent can register them alongside the new address.
module strip_vertex_sequencer
    import vfetch_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] vertex_count,
    output logic [COUNT_WIDTH-1:0] vertex_idx,
    output logic [1:0]             vertex_offset,
    output logic                   last_vertex,
    output logic                   tri_advance,
    output logic                   tri_wrap
);

    logic [COUNT_WIDTH-1:0] tri_q, tri_d;
    logic [1:0]             corner_q, corner_d;
    logic                   strip_mode;

    assign strip_mode = (mode == MODE_STRIP);

    // Next position: restart on load, otherwise corner/triangle or vertex step
    always_comb begin
        tri_d       = tri_q;
        corner_d    = corner_q;
        tri_advance = 1'b0;
        tri_wrap    = 1'b0;
        if (load) begin
            tri_d    = '0;
            corner_d = '0;
        end else if (step) begin
            if (strip_mode) begin
                if (corner_q == 2'd2) begin
                    corner_d    = 2'd0;
                    tri_d       = tri_q + COUNT_WIDTH'(1);
                    tri_advance = 1'b1;
                end else begin
                    corner_d = corner_q + 2'd1;
                end
            end else if ((mode == MODE_REPEAT) && (tri_q == vertex_count - COUNT_WIDTH'(1))) begin
                tri_d    = '0;
                tri_wrap = 1'b1;
            end else begin
                tri_d       = tri_q + COUNT_WIDTH'(1);
                tri_advance = 1'b1;
            end
        end
    end

    // Source vertex and end-of-pass flag for the position being moved to
    always_comb begin
        vertex_offset = strip_mode ? strip_corner_offset(tri_d[0], corner_d) : 2'd0;
        vertex_idx    = tri_d + COUNT_WIDTH'(vertex_offset);
        if (strip_mode) begin
            last_vertex = (tri_d == vertex_count - COUNT_WIDTH'(3)) && (corner_d == 2'd2);
        end else if (mode == MODE_LINEAR) begin
            last_vertex = (tri_d == vertex_count - COUNT_WIDTH'(1));
        end else begin
            last_vertex = 1'b0;
        end
    end

    // Position register, only moves on load or vertex step
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q    <= '0;
            corner_q <= '0;
        end else if (load || step) begin
            tri_q    <= tri_d;
            corner_q <= corner_d;
        end
    end

endmodule

// File: rtl/vertex_fetch_addr_gen.sv
// Vertex buffer word address generator. Walks base + vertex*stride + word
// using a running vertex-start sum, in LINEAR, STRIP (expanded triangles)
// or REPEAT order, one address per valid/ready transfer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; config inputs watched, nothing emitted
// RUN     | addr_valid high; one address presented per cycle/transfer
// DONE    | one-cycle done pulse after the final transfer or empty pass
module vertex_fetch_addr_gen
    import vfetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int WPV_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  stride,
    input  logic [WPV_WIDTH-1:0]   words_per_vertex,
    input  logic [COUNT_WIDTH-1:0] vertex_count,
    input  logic                   addr_ready,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   addr_valid,
    output logic [COUNT_WIDTH-1:0] vertex_idx,
    output logic [WPV_WIDTH-1:0]   word_idx,
    output logic                   addr_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_t state_q, state_d;

    logic [1:0]             cfg_mode;
    logic [ADDR_WIDTH-1:0]  cfg_base, cfg_stride;
    logic [WPV_WIDTH-1:0]   cfg_wpv;
    logic [COUNT_WIDTH-1:0] cfg_count;

    logic [1:0]             eff_mode;
    logic [ADDR_WIDTH-1:0]  eff_stride;
    logic [WPV_WIDTH-1:0]   eff_wpv;
    logic [COUNT_WIDTH-1:0] eff_count;

    logic [WPV_WIDTH-1:0]   word_q, word_nxt;
    logic [ADDR_WIDTH-1:0]  vbase_q, vbase_nxt, vofs, addr_nxt;

    logic xfer, cfg_bad, start_ok, empty_pass, advance, word_wrap, seq_step;
    logic last_nxt, out_load, run_d, done_d, err_d, run_q;

    logic [COUNT_WIDTH-1:0] seq_vertex;
    logic [1:0]             seq_offset;
    logic                   seq_last, seq_tri_adv, seq_tri_wrap;

    assign xfer       = addr_valid & addr_ready;
    assign cfg_bad    = (mode == MODE_RSVD) || (words_per_vertex == '0);
    assign start_ok   = (state_q == ST_IDLE) && start && !abort && !cfg_bad;
    assign empty_pass = (mode == MODE_STRIP) ? (vertex_count < COUNT_WIDTH'(3))
                                             : (vertex_count == '0);
    assign advance    = (state_q == ST_RUN) && xfer && !abort;
    assign word_wrap  = (word_q == cfg_wpv - WPV_WIDTH'(1));
    assign seq_step   = advance && word_wrap;

    // On the start cycle the config registers are not loaded yet, so the
    // first address is built straight from the inputs.
    assign eff_mode   = start_ok ? mode             : cfg_mode;
    assign eff_stride = start_ok ? stride           : cfg_stride;
    assign eff_wpv    = start_ok ? words_per_vertex : cfg_wpv;
    assign eff_count  = start_ok ? vertex_count     : cfg_count;

    strip_vertex_sequencer #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .load          (start_ok),
        .step          (seq_step),
        .mode          (eff_mode),
        .vertex_count  (eff_count),
        .vertex_idx    (seq_vertex),
        .vertex_offset (seq_offset),
        .last_vertex   (seq_last),
        .tri_advance   (seq_tri_adv),
        .tri_wrap      (seq_tri_wrap)
    );

    // Next word, running vertex start and resulting address
    always_comb begin
        word_nxt = (start_ok || word_wrap) ? '0 : word_q + WPV_WIDTH'(1);
        if (start_ok) begin
            vbase_nxt = base_addr;
        end else if (seq_tri_wrap) begin
            vbase_nxt = cfg_base;
        end else if (seq_tri_adv) begin
            vbase_nxt = vbase_q + cfg_stride;
        end else begin
            vbase_nxt = vbase_q;
        end
        case (seq_offset)
            2'd1:    vofs = eff_stride;
            2'd2:    vofs = {eff_stride[ADDR_WIDTH-2:0], 1'b0};
            default: vofs = '0;
        endcase
        addr_nxt = vbase_nxt + vofs + ADDR_WIDTH'(word_nxt);
        last_nxt = seq_last && (word_nxt == eff_wpv - WPV_WIDTH'(1));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort overrides everything including a final transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = empty_pass ? ST_DONE : ST_RUN;
            ST_RUN:  if (advance && addr_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // FSM output decode feeding the output register stage
    always_comb begin
        run_d    = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_q == ST_IDLE) && start && !abort && cfg_bad;
        out_load = run_d && (start_ok || advance);
    end

    // Config capture and walk counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode   <= '0;
            cfg_base   <= '0;
            cfg_stride <= '0;
            cfg_wpv    <= '0;
            cfg_count  <= '0;
            word_q     <= '0;
            vbase_q    <= '0;
        end else begin
            if (start_ok) begin
                cfg_mode   <= mode;
                cfg_base   <= base_addr;
                cfg_stride <= stride;
                cfg_wpv    <= words_per_vertex;
                cfg_count  <= vertex_count;
            end
            if (start_ok || advance) begin
                word_q  <= word_nxt;
                vbase_q <= vbase_nxt;
            end
        end
    end

    // Output register stage; address fields hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= '0;
            vertex_idx <= '0;
            word_idx   <= '0;
            addr_last  <= 1'b0;
        end else begin
            run_q <= run_d;
            done  <= done_d;
            err   <= err_d;
            if (out_load) begin
                mem_addr   <= addr_nxt;
                vertex_idx <= seq_vertex;
                word_idx   <= word_nxt;
                addr_last  <= last_nxt;
            end
        end
    end

    // In RUN an address is always on offer, so valid and busy coincide
    assign addr_valid = run_q;
    assign busy       = run_q;

endmodule

// File: tb/tb_vertex_fetch_addr_gen.sv
// Scoreboard bench for vertex_fetch_addr_gen: the driver pushes the expected
// address stream from a list-based model, the monitor pops on each transfer.
module tb_vertex_fetch_addr_gen;

    localparam int AW = 8;
    localparam int CW = 8;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          rst, start, abort, addr_ready;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr, stride;
    logic [WW-1:0] words_per_vertex;
    logic [CW-1:0] vertex_count;
    logic [AW-1:0] mem_addr;
    logic          addr_valid, addr_last, busy, done, err;
    logic [CW-1:0] vertex_idx;
    logic [WW-1:0] word_idx;

    typedef struct {
        int addr;
        int vidx;
        int widx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vertex_fetch_addr_gen #(
        .ADDR_WIDTH  (AW),
        .COUNT_WIDTH (CW),
        .WPV_WIDTH   (WW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .mode             (mode),
        .base_addr        (base_addr),
        .stride           (stride),
        .words_per_vertex (words_per_vertex),
        .vertex_count     (vertex_count),
        .addr_ready       (addr_ready),
        .mem_addr         (mem_addr),
        .addr_valid       (addr_valid),
        .vertex_idx       (vertex_idx),
        .word_idx         (word_idx),
        .addr_last        (addr_last),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list the source vertices in fetch order, then expand words.
    task automatic push_expected(input int m, input int b, input int s, input int w,
                                 input int c, input int reps, output int n);
        int verts[$];
        if (m == 0) begin
            for (int v = 0; v < c; v++) verts.push_back(v);
        end else if (m == 1) begin
            for (int k = 0; k <= c - 3; k++) begin
                if (k % 2 == 0) begin
                    verts.push_back(k); verts.push_back(k + 1); verts.push_back(k + 2);
                end else begin
                    verts.push_back(k + 1); verts.push_back(k); verts.push_back(k + 2);
                end
            end
        end else begin
            for (int r = 0; r < reps; r++)
                for (int v = 0; v < c; v++) verts.push_back(v);
        end
        n = 0;
        for (int i = 0; i < verts.size(); i++) begin
            for (int j = 0; j < w; j++) begin
                exp_t e;
                e.addr = (b + verts[i] * s + j) % 256;
                e.vidx = verts[i];
                e.widx = j;
                e.last = (m != 2 && i == verts.size() - 1 && j == w - 1) ? 1 : 0;
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    function automatic logic ready_for(input int rmode, input int cyc);
        int pat[4];
        pat = '{1, 0, 0, 1};
        case (rmode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return 1'(pat[cyc % 4]);
        endcase
    endfunction

    // Monitor: compare the presented address against the scoreboard head;
    // pop only on a real transfer, so stalled cycles check the hold.
    always @(negedge clk) begin
        if (!rst && addr_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_addr_queue_len", exp_q.size(), 1);
            end else begin
                check("mem_addr",   mem_addr,   exp_q[0].addr);
                check("vertex_idx", vertex_idx, exp_q[0].vidx);
                check("word_idx",   word_idx,   exp_q[0].widx);
                check("addr_last",  addr_last,  exp_q[0].last);
                if (addr_ready && !abort) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_cfg(input int m, input int b, input int s, input int w, input int c);
        mode             = 2'(m);
        base_addr        = AW'(b);
        stride           = AW'(s);
        words_per_vertex = WW'(w);
        vertex_count     = CW'(c);
    endtask

    task automatic run_pass(input int m, input int b, input int s, input int w,
                            input int c, input int rmode);
        int n;
        int cyc;
        push_expected(m, b, s, w, c, 0, n);
        @(posedge clk); #1;
        drive_cfg(m, b, s, w, c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("first_valid", addr_valid, (n > 0) ? 1 : 0);
        check("busy_after_start", busy, (n > 0) ? 1 : 0);
        cyc = 0;
        addr_ready = ready_for(rmode, cyc);
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            check("no_err_in_run", err, 0);
            if (!done) begin
                addr_ready = ready_for(rmode, cyc);
                start = 1'($urandom_range(0, 3) == 0);
                drive_cfg($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 7), $urandom);
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (rmode == 0) check("done_latency", cyc, n);
        check("queue_drained", exp_q.size(), 0);
        check("valid_in_done", addr_valid, 0);
        exp_q.delete();
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic reject_start(input int m, input int w);
        @(posedge clk); #1;
        drive_cfg(m, 8'h30, 2, w, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_valid", addr_valid, 0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        check("err_no_done", done, 0);
    endtask

    task automatic repeat_abort(input int b, input int s, input int w, input int c, input int ncyc);
        int n;
        push_expected(2, b, s, w, c, 60, n);
        @(posedge clk); #1;
        drive_cfg(2, b, s, w, c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            addr_ready = ready_for(1, i);
            @(posedge clk); #1;
            check("repeat_no_done", done, 0);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", addr_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_addr_valid"}, addr_valid, 0);
        check({tag, "_vertex_idx"}, vertex_idx, 0);
        check({tag, "_word_idx"},   word_idx,   0);
        check({tag, "_addr_last"},  addr_last,  0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_pass(0, 8'h10, 4, 2, 3, 0);   // 10,11,14,15,18,19
        run_pass(1, 0, 1, 1, 5, 0);       // 0,1,2, 2,1,3, 2,3,4
        run_pass(0, 8'h20, 3, 3, 4, 2);   // backpressure 1,0,0,1
        run_pass(1, 8'h40, 5, 2, 2, 0);   // strip count 2: empty
        run_pass(0, 8'hFE, 1, 1, 3, 0);   // FE,FF,00
        run_pass(0, 8'h05, 7, 2, 0, 0);   // linear count 0: empty
        run_pass(2, 8'h05, 7, 2, 0, 0);   // repeat count 0 terminates
        run_pass(0, 8'h80, 9, 7, 1, 1);   // single vertex, full wpv
        reject_start(3, 2);
        reject_start(0, 0);
        repeat_abort(0, 1, 1, 2, 20);
        repeat_abort(8'hF0, 13, 3, 3, 30);

        // reset mid-strip, then a clean pass
        begin
            int n;
            push_expected(1, 8'h11, 3, 2, 8, 0, n);
            @(posedge clk); #1;
            drive_cfg(1, 8'h11, 3, 2, 8);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            addr_ready = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            check_all_zero("midreset");
            rst = 1'b0;
            exp_q.delete();
        end
        run_pass(1, 8'h11, 3, 2, 8, 0);

        for (int t = 0; t < 24; t++) begin
            run_pass($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(1, 7), $urandom_range(0, 10), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
